// File: rtl/fetch_unit_pkg.sv
// Shared instruction-format definitions for the minimicro fetch/decode boundary.
// Field positions, opcode/branch encodings and fetch FSM states.
package fetch_unit_pkg;

  localparam int INSTR_W = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int BR_MSB  = 12;
  localparam int BR_LSB  = 11;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RN_MSB  = 7;
  localparam int RN_LSB  = 5;
  localparam int RM_MSB  = 4;
  localparam int RM_LSB  = 2;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_ORR = 3'd3,
    OP_MOV = 3'd4,
    OP_LDR = 3'd5,
    OP_STR = 3'd6,
    OP_BR  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    BEQ     = 2'd0,
    BMI     = 2'd1,
    BAL     = 2'd2,
    BR_RSVD = 2'd3
  } branch_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer holding {pc, instr} entries with single-cycle flush.
// Head entry is read combinationally so a pushed entry is visible the next cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_reg != '0);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage has no reset; the empty flag masks stale contents downstream.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;
  assign empty     = (count_reg == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, imem request/response tracking,
// redirect flush with stale-response dropping, and pre-split decode fields.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [15:0]       imem_rdata,
  input  logic              pc_sel,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output opcode_t           id_op_code,
  output branch_t           id_branch,
  output logic [2:0]        id_rd,
  output logic [2:0]        id_rn,
  output logic [2:0]        id_rm,
  output logic [7:0]        id_imm
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int SUM_W   = CNT_W + 2;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [1:0]        rst_sync_reg;
  logic              rst_int_n;
  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;
  logic [CNT_W-1:0]  drop_after, out_after;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] head_data, head_vis;
  logic [SUM_W-1:0]  in_use;
  logic              accept, rsp_drop, rsp_keep, fifo_push, fifo_pop;
  logic [ADDR_W-1:0] target_aligned;
  logic              unused_target_lsb;

  // Reset asserts immediately, releases two clock edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  assign target_aligned    = {branch_target[ADDR_W-1:1], 1'b0};
  assign unused_target_lsb = branch_target[0];

  // Every slot is reserved by a buffered entry, an in-flight fetch or a pending drop.
  assign in_use   = SUM_W'(fifo_count) + SUM_W'(outstanding_reg) + SUM_W'(drop_cnt_reg);
  assign imem_req = (state_reg != ST_BOOT) && !pc_sel && (in_use < SUM_W'(DEPTH));
  assign imem_addr = fetch_pc_reg;

  assign accept    = imem_req && imem_ready;
  assign rsp_drop  = imem_rvalid && (drop_cnt_reg != '0);
  assign rsp_keep  = imem_rvalid && (drop_cnt_reg == '0) && (outstanding_reg != '0);
  assign fifo_push = rsp_keep && !pc_sel;
  assign id_valid  = !fifo_empty && !pc_sel;
  assign fifo_pop  = id_valid && id_ready;

  assign drop_after = drop_cnt_reg - CNT_W'(rsp_drop);
  assign out_after  = outstanding_reg + CNT_W'(accept) - CNT_W'(rsp_keep);

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = out_after;
    drop_cnt_next    = drop_after;
    if (accept)    fetch_pc_next = fetch_pc_reg + ADDR_W'(2);
    if (fifo_push) resp_pc_next  = resp_pc_reg + ADDR_W'(2);
    // Everything still in flight becomes stale, including a response kept this cycle.
    if (pc_sel) begin
      fetch_pc_next    = target_aligned;
      resp_pc_next     = target_aligned;
      drop_cnt_next    = drop_after + out_after;
      outstanding_next = '0;
    end
    case (state_reg)
      ST_BOOT:           state_next = ST_RUN;
      ST_RUN, ST_DRAIN:  state_next = (drop_cnt_next != '0) ? ST_DRAIN : ST_RUN;
      default:           state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg       <= ST_BOOT;
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .flush     (pc_sel),
    .push      (fifo_push),
    .push_data ({resp_pc_reg, imem_rdata}),
    .pop       (fifo_pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign head_vis   = fifo_empty ? '0 : head_data;
  assign id_pc      = head_vis[ENTRY_W-1:INSTR_W];
  assign id_op_code = opcode_t'(head_vis[OPC_MSB:OPC_LSB]);
  assign id_branch  = branch_t'(head_vis[BR_MSB:BR_LSB]);
  assign id_rd      = head_vis[RD_MSB:RD_LSB];
  assign id_rn      = head_vis[RN_MSB:RN_LSB];
  assign id_rm      = head_vis[RM_MSB:RM_LSB];
  assign id_imm     = head_vis[IMM_MSB:IMM_LSB];

  // A response with nothing in flight is a memory protocol violation and is ignored.
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst_int_n)
    imem_rvalid |-> ((outstanding_reg != '0) || (drop_cnt_reg != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model, directed scenarios and random redirects.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          ADDR_W   = 16;
  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        pc_sel;
  logic [15:0] branch_target;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_pc;
  opcode_t     id_op_code;
  branch_t     id_branch;
  logic [2:0]  id_rd, id_rn, id_rm;
  logic [7:0]  id_imm;

  fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_sel(pc_sel), .branch_target(branch_target), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_op_code(id_op_code),
    .id_branch(id_branch), .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm),
    .id_imm(id_imm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction memory contents: address 0 holds 0x2A44.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'(a * 16'd40503) ^ 16'h2A44;
  endfunction

  function automatic logic [37:0] exp_vec(input logic [15:0] pc);
    logic [15:0] w;
    w = mem_word(pc);
    return {pc, w[15:13], w[12:11], w[10:8], w[7:5], w[4:2], w[7:0]};
  endfunction

  function automatic logic [37:0] act_vec();
    return {id_pc, id_op_code, id_branch, id_rd, id_rn, id_rm, id_imm};
  endfunction

  // Architectural model: after reset or redirect, decode sees target, target+2, ...
  logic [15:0] exp_q[$];
  task automatic fill_exp(input logic [15:0] start);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back(start + 16'(2 * i));
  endtask

  // Memory model: in-order responses, per-request latency >= 1.
  typedef struct packed { logic [15:0] addr; int due; } pend_t;
  pend_t       pend_q[$];
  logic [15:0] acc_log[$];
  int          mem_lat   = 1;
  int          ready_pct = 100;
  int          pick_lat;

  initial begin
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      imem_ready = ($urandom_range(99) < ready_pct);
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(pend_q[0].addr);
      end else begin
        imem_rvalid = 1'b0; imem_rdata = '0;
      end
      @(negedge clk);
      if (!rst_n) begin
        pend_q.delete();
      end else begin
        if (imem_rvalid) void'(pend_q.pop_front());
        if (imem_req && imem_ready) begin
          pick_lat = (mem_lat == 0) ? $urandom_range(3, 1) : mem_lat;
          pend_q.push_back('{addr: imem_addr, due: cyc + pick_lat});
          acc_log.push_back(imem_addr);
        end
      end
    end
  end

  // Monitor: compare every consumed head entry against the model.
  logic [15:0] mon_pc;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pc_sel) check("id_valid_in_redirect", id_valid, 0);
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          mon_pc = exp_q.pop_front();
          check("id_entry", act_vec(), exp_vec(mon_pc));
          $display("txn cyc=%0d pc=%04h op=%0d br=%0d rd=%0d rn=%0d rm=%0d imm=%02h",
                   cyc, id_pc, id_op_code, id_branch, id_rd, id_rn, id_rm, id_imm);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic redirect(input logic [15:0] tgt);
    pc_sel = 1'b1; branch_target = tgt;
    fill_exp({tgt[15:1], 1'b0});
    acc_log.delete();
    step();
    pc_sel = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string name);
    int t;
    t = 0;
    while (acc_log.size() < n && t < 40) begin step(); t++; end
    if (acc_log.size() < n) check(name, acc_log.size(), n);
    while (acc_log.size() < n) acc_log.push_back(16'hDEAD);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] acc_a[$];
  int          acc_c[$];
  int          first_v, n_acc, t;
  logic [15:0] f_pc;
  logic [2:0]  f_op, f_rd, f_rn, f_rm;
  logic [1:0]  f_br;
  logic [7:0]  f_imm;

  initial begin
    rst_n = 1'b1; pc_sel = 1'b0; branch_target = '0; id_ready = 1'b0;
    #1 rst_n = 1'b0; fill_exp(RESET_PC);
    #3;
    check("reset_imem_req", imem_req, 0);
    check("reset_id_valid", id_valid, 0);
    check("reset_id_pc", id_pc, 0);
    check("reset_id_fields", {id_op_code, id_branch, id_rd, id_rn, id_rm, id_imm}, 0);
    repeat (2) step();

    // Basic streaming with 1-cycle memory.
    id_ready = 1'b1; mem_lat = 1; ready_pct = 100;
    rst_n = 1'b1;
    first_v = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (imem_req && imem_ready) begin acc_a.push_back(imem_addr); acc_c.push_back(cyc); end
      if (id_valid && first_v < 0) begin
        first_v = cyc; f_pc = id_pc; f_op = id_op_code; f_br = id_branch;
        f_rd = id_rd; f_rn = id_rn; f_rm = id_rm; f_imm = id_imm;
      end
    end
    while (acc_a.size() < 3) begin acc_a.push_back(16'hDEAD); acc_c.push_back(-100); end
    check("t1_addr0", acc_a[0], 16'h0000);
    check("t1_addr1", acc_a[1], 16'h0002);
    check("t1_addr2", acc_a[2], 16'h0004);
    check("t1_first_valid_latency", first_v - acc_c[0], 2);
    check("t1_first_pc", f_pc, 16'h0000);
    check("t1_op_code", f_op, 3'd1);
    check("t1_branch", f_br, 2'd1);
    check("t1_rd", f_rd, 3'd2);
    check("t1_rn", f_rn, 3'd2);
    check("t1_rm", f_rm, 3'd1);
    check("t1_imm", f_imm, 8'h44);

    // Backpressure from reset: only DEPTH fetches may be taken.
    step();
    rst_n = 1'b0; fill_exp(RESET_PC);
    repeat (2) step();
    id_ready = 1'b0; rst_n = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (imem_req && imem_ready) n_acc++;
    end
    check("bp_accepts", n_acc, DEPTH);
    check("bp_req_low", imem_req, 0);
    check("bp_valid", id_valid, 1);
    check("bp_head_pc", id_pc, 16'h0000);
    step();
    id_ready = 1'b1;
    repeat (6) step();

    // Redirect with two fetches in flight on a 3-cycle memory.
    mem_lat = 3;
    t = 0;
    while (!(pend_q.size() == 2 && !imem_rvalid) && t < 50) begin step(); t++; end
    check("rd3_two_in_flight", pend_q.size(), 2);
    pc_sel = 1'b1; branch_target = 16'h0041; fill_exp(16'h0040); acc_log.delete();
    @(negedge clk);
    check("rd3_req_in_redirect", imem_req, 0);
    step();
    pc_sel = 1'b0;
    wait_acc(1, "rd3_timeout");
    check("rd3_next_addr", acc_log[0], 16'h0040);
    repeat (20) step();

    // Redirect in the same cycle as a returning response.
    mem_lat = 1;
    repeat (6) step();
    t = 0;
    while (!imem_rvalid && t < 40) begin step(); t++; end
    check("same_cycle_rvalid", imem_rvalid, 1);
    redirect(16'h0100);
    wait_acc(1, "same_cycle_timeout");
    check("same_cycle_next_addr", acc_log[0], 16'h0100);
    repeat (12) step();

    // Address wrap-around, with the odd target bit ignored.
    redirect(16'hFFFF);
    wait_acc(2, "wrap_timeout");
    check("wrap_addr0", acc_log[0], 16'hFFFE);
    check("wrap_addr1", acc_log[1], 16'h0000);
    repeat (12) step();

    // Randomised traffic with random redirects and memory timing.
    ready_pct = 75; mem_lat = 0;
    for (int i = 0; i < 500; i++) begin
      id_ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 4) begin
        pc_sel = 1'b1; branch_target = 16'($urandom);
        fill_exp({branch_target[15:1], 1'b0});
      end else begin
        pc_sel = 1'b0;
      end
      step();
    end
    pc_sel = 1'b0; ready_pct = 100; mem_lat = 1; id_ready = 1'b1;
    repeat (12) step();

    // Asynchronous reset with a full FIFO.
    id_ready = 1'b0;
    repeat (10) step();
    check("mr_full_valid", id_valid, 1);
    #1 rst_n = 1'b0; fill_exp(RESET_PC); acc_log.delete();
    #1;
    check("mr_req_immediate", imem_req, 0);
    check("mr_valid_immediate", id_valid, 0);
    repeat (3) step();
    rst_n = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    check("mr_no_req_after_release", imem_req, 0);
    wait_acc(1, "mr_restart_timeout");
    check("mr_restart_addr", acc_log[0], RESET_PC);
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
